// File: rtl/coproc_pkg.sv
// Shared types and default widths for the coprocessor blocks that sit on the BRAM.
package coproc_pkg;
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT_DATA,
    SEND,
    WAIT_ACK,
    WAIT_TX,
    FINISH
  } sender_state_e;
endpackage

// File: rtl/bram_uart_sender_if.sv
// Control, BRAM port-B and UART-side signals of the block sender.
interface bram_uart_sender_if
  import coproc_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   length;
  logic                  busy;
  logic                  done;
  logic                  enb;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [DATA_WIDTH-1:0] doutb;
  logic                  tx_start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_busy;

  modport master (
    input  start, base_addr, length, doutb, tx_busy,
    output busy, done, enb, addrb, tx_start, tx_data
  );

  modport slave (
    output start, base_addr, length, doutb, tx_busy,
    input  busy, done, enb, addrb, tx_start, tx_data
  );
endinterface

// File: rtl/bram_uart_sender.sv
// Streams a block of BRAM bytes to a UART transmitter, one read/send handshake per byte.
module bram_uart_sender
  import coproc_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  bram_uart_sender_if.master bus
);

  sender_state_e           state, state_nx;
  logic [ADDR_WIDTH:0]     cnt;
  logic [ADDR_WIDTH:0]     len_q;
  logic [READ_LATENCY-1:0] vld_pipe;
  logic                    cnt_last;

  // Counter is one bit wider than the address so a full 1024-byte block terminates.
  assign cnt_last = (cnt + 1'b1) == len_q;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (bus.start) state_nx = (bus.length == '0) ? FINISH : READ;
      READ:      state_nx = WAIT_DATA;
      WAIT_DATA: if (vld_pipe[READ_LATENCY-1]) state_nx = SEND;
      SEND:      state_nx = WAIT_ACK;
      WAIT_ACK:  if (bus.tx_busy) state_nx = WAIT_TX;
      WAIT_TX:   if (!bus.tx_busy) state_nx = cnt_last ? FINISH : READ;
      FINISH:    state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      len_q        <= '0;
      vld_pipe     <= '0;
      bus.enb      <= 1'b0;
      bus.addrb    <= '0;
      bus.tx_start <= 1'b0;
      bus.tx_data  <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      state        <= state_nx;
      bus.enb      <= (state_nx == READ);
      bus.tx_start <= (state_nx == SEND);
      bus.done     <= (state_nx == FINISH);
      bus.busy     <= (state_nx != IDLE);

      // vld_pipe[k] marks that the read was issued k+1 cycles ago.
      vld_pipe[0] <= (state == READ);
      for (int i = 1; i < READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];

      case (state)
        IDLE: if (bus.start) begin
          len_q     <= bus.length;
          cnt       <= '0;
          bus.addrb <= bus.base_addr;
        end
        WAIT_DATA: if (vld_pipe[READ_LATENCY-1]) bus.tx_data <= bus.doutb;
        WAIT_TX: if (!bus.tx_busy) begin
          cnt       <= cnt + 1'b1;
          bus.addrb <= bus.addrb + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_uart_sender.sv
// Bench for bram_uart_sender: BRAM and UART models, directed table, corner sequences, random blocks.
module tb_bram_uart_sender;
  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int RL    = 1;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bram_uart_sender_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  bram_uart_sender #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // BRAM port B (latency 1) and UART (busy uart_len cycles starting 1 cycle after tx_start)
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] dout_q = '0;
  int ucnt = 0;
  int uart_len = 10;
  always @(posedge clk) begin
    if (bus.enb) dout_q <= mem[bus.addrb];
    if (bus.tx_start) ucnt <= uart_len;
    else if (ucnt > 0) ucnt <= ucnt - 1;
  end
  assign bus.doutb   = dout_q;
  assign bus.tx_busy = (ucnt != 0);

  int checks = 0;
  int errors = 0;

  int txs_cnt = 0, enb_cnt = 0, done_cnt = 0;
  logic [DW-1:0] got_q [$];
  logic [AW-1:0] addr_q [$];
  logic prev_enb = 1'b0;
  logic [DW-1:0] last_tx = '0;

  always @(negedge clk) begin
    if (bus.tx_start === 1'b1) begin
      txs_cnt++;
      got_q.push_back(bus.tx_data);
      last_tx = bus.tx_data;
      checks++;
      if (bus.tx_busy !== 1'b0) begin
        errors++;
        $display("FAIL tx_start_overlap: tx_busy=%0b required 0", bus.tx_busy);
      end
    end else if (bus.busy === 1'b1 && bus.tx_busy === 1'b1) begin
      checks++;
      if (bus.tx_data !== last_tx) begin
        errors++;
        $display("FAIL tx_data_hold: got %0h required %0h", bus.tx_data, last_tx);
      end
    end
    if (bus.enb === 1'b1) begin
      enb_cnt++;
      addr_q.push_back(bus.addrb);
      checks++;
      if (prev_enb) begin
        errors++;
        $display("FAIL enb_width: enb high %0d cycles in a row, required 1", 2);
      end
    end
    prev_enb = (bus.enb === 1'b1);
    if (bus.done === 1'b1) done_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    txs_cnt = 0; enb_cnt = 0; done_cnt = 0;
    got_q.delete(); addr_q.delete();
  endtask

  task automatic pulse_start(input int base, input int len);
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = AW'(base); bus.length = (AW+1)'(len);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Entered one cycle after start was sampled; cyc counts cycles from start to done.
  task automatic wait_done(input string name, output int cyc);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_done_seen"}, int'(bus.done === 1'b1), 1);
    chk({name, "_busy_at_done"}, int'(bus.busy === 1'b1), 1);
    @(negedge clk);
    chk({name, "_busy_after_done"}, int'(bus.busy === 1'b1), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_bytes(input string name, input int n);
    int w = 0;
    while (txs_cnt < n && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk({name, "_reached"}, txs_cnt, n);
  endtask

  // Reference: a block is exactly len reads of (base+k) mod DEPTH, sending mem at each address.
  task automatic chk_stream(input string name, input int base, input int len);
    int bad;
    int a;
    bad = 0;
    chk({name, "_nbytes"}, got_q.size(), len);
    chk({name, "_nreads"}, addr_q.size(), len);
    chk({name, "_ndone"}, done_cnt, 1);
    for (int k = 0; k < len && k < got_q.size() && k < addr_q.size(); k++) begin
      a = (base + k) % DEPTH;
      if (int'(addr_q[k]) != a || got_q[k] != mem[a]) bad++;
    end
    chk({name, "_order"}, bad, 0);
  endtask

  task automatic run(input string name, input int base, input int len, output int cyc);
    clear_mon();
    pulse_start(base, len);
    wait_done(name, cyc);
    chk_stream(name, base, len);
  endtask

  typedef struct {
    int base;
    int len;
    int exp_first;
    int exp_last;
    int max_cyc;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int cyc;
    int b, l;

    vecs[0] = '{'h005, 4, 'h05, 'h08, 100};
    vecs[1] = '{'h3FE, 4, 'hFE, 'h01, 100};
    vecs[2] = '{'h000, 0, 0,    0,    2};
    vecs[3] = '{'h3FF, 1, 'hFF, 'hFF, 30};
    vecs[4] = '{'h0FF, 3, 'hFF, 'h01, 80};

    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);

    rst = 1'b1; bus.start = 1'b0; bus.base_addr = '0; bus.length = '0;
    repeat (3) @(negedge clk);
    chk("rst_enb", int'(bus.enb), 0);
    chk("rst_addrb", int'(bus.addrb), 0);
    chk("rst_tx_start", int'(bus.tx_start), 0);
    chk("rst_tx_data", int'(bus.tx_data), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run($sformatf("vec%0d", i), vecs[i].base, vecs[i].len, cyc);
      chk($sformatf("vec%0d_latency_ok", i), int'(cyc <= vecs[i].max_cyc), 1);
      chk($sformatf("vec%0d_tx_starts", i), txs_cnt, vecs[i].len);
      if (got_q.size() > 0) begin
        chk($sformatf("vec%0d_first", i), int'(got_q[0]), vecs[i].exp_first);
        chk($sformatf("vec%0d_last", i), int'(got_q[got_q.size()-1]), vecs[i].exp_last);
      end
    end

    // A second start during byte 2 must not disturb the running block.
    clear_mon();
    pulse_start('h010, 3);
    wait_bytes("ign_byte2", 2);
    pulse_start('h200, 5);
    wait_done("ign", cyc);
    chk_stream("ign", 'h010, 3);
    repeat (20) @(negedge clk);
    chk("ign_no_extra_tx", txs_cnt, 3);
    chk("ign_no_extra_done", done_cnt, 1);

    // Reset while waiting for byte 2 to drain.
    clear_mon();
    pulse_start('h020, 4);
    wait_bytes("mid_byte2", 2);
    repeat (3) @(negedge clk);
    chk("mid_in_wait_tx", int'(bus.tx_busy === 1'b1 && bus.busy === 1'b1), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_enb", int'(bus.enb), 0);
    chk("mid_rst_addrb", int'(bus.addrb), 0);
    chk("mid_rst_tx_start", int'(bus.tx_start), 0);
    chk("mid_rst_tx_data", int'(bus.tx_data), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    repeat (30) @(negedge clk);
    chk("mid_no_more_tx", txs_cnt, 2);
    chk("mid_no_done", done_cnt, 0);
    run("after_rst", 'h007, 2, cyc);
    chk("after_rst_first", int'(got_q.size() > 0 ? got_q[0] : 8'hxx), 'h07);

    // Reset wins over a simultaneous start.
    clear_mon();
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.base_addr = AW'(3); bus.length = (AW+1)'(2);
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    chk("rst_dom_busy", int'(bus.busy), 0);
    repeat (5) @(negedge clk);
    chk("rst_dom_busy_later", int'(bus.busy), 0);
    chk("rst_dom_no_reads", enb_cnt, 0);

    run("full", 0, 1024, cyc);
    chk("full_tx_starts", txs_cnt, 1024);

    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    for (int t = 0; t < 6; t++) begin
      b = int'($urandom_range(0, DEPTH - 1));
      l = int'($urandom_range(1, 40));
      uart_len = int'($urandom_range(1, 12));
      run($sformatf("rnd%0d", t), b, l, cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_uart_sender.md
BRAM_UART_SENDER -- requirements
Module: bram_uart_sender

Interface
REQ-001 Parameter ADDR_WIDTH, 10, BRAM address width.
REQ-002 Parameter DATA_WIDTH, 8, BRAM word and UART byte width.
REQ-003 Parameter READ_LATENCY, 1, cycles from enb/addrb to valid doutb (1..3).
REQ-004 clk  input  1  single clock, all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to send a block.
REQ-007 base_addr  input  ADDR_WIDTH  first BRAM address, sampled with start.
REQ-008 length  input  ADDR_WIDTH+1  byte count (0..1024), sampled with start.
REQ-009 enb  output  1  BRAM port-B enable.
REQ-010 addrb  output  ADDR_WIDTH  BRAM port-B address.
REQ-011 doutb  input  DATA_WIDTH  BRAM port-B read data.
REQ-012 tx_start  output  1  one-cycle pulse to UART transmitter.
REQ-013 tx_data  output  DATA_WIDTH  byte to transmit, held stable from tx_start until tx_busy falls.
REQ-014 tx_busy  input  1  UART transmitter busy.
REQ-015 busy  output  1  high from accepted start until done.
REQ-016 done  output  1  one-cycle pulse when block is finished.

Function
REQ-017 SHALL implement states IDLE, READ, WAIT_DATA, SEND, WAIT_ACK, WAIT_TX, FINISH.
REQ-018 IDLE: start=1 with length>0 SHALL latch base_addr/length, clear byte counter, go READ, busy=1 next cycle.
REQ-019 start=1 with length=0 SHALL skip transfer: FINISH next cycle, done pulse, no enb, no tx_start.
REQ-020 start while busy=1 SHALL be ignored; latched parameters unchanged.
REQ-021 READ: enb=1 for exactly one cycle, addrb=(base+count) mod 2^ADDR_WIDTH (wrap 1023->0).
REQ-022 WAIT_DATA: count READ_LATENCY cycles after READ, then capture doutb into tx_data register; enb=0.
REQ-023 SEND: tx_start=1 for exactly one cycle, then WAIT_ACK.
REQ-024 WAIT_ACK: wait for tx_busy=1, then WAIT_TX; tx_busy already high at entry SHALL advance next cycle.
REQ-025 WAIT_TX: wait for tx_busy=0; then count+1; if count+1==length go FINISH else READ.
REQ-026 FINISH: done=1 one cycle, busy=0 from following cycle, return IDLE.
REQ-027 Bytes SHALL be sent in ascending address order, exactly length bytes, none repeated or dropped.
REQ-028 Byte counter SHALL be ADDR_WIDTH+1 bits so length=1024 completes without overflow.
REQ-029 tx_start SHALL never assert while tx_busy=1 from a previous byte.

Reset
REQ-030 rst=1 SHALL force IDLE at next edge from any state, including mid-byte.
REQ-031 Reset values: enb=0, addrb=0, tx_start=0, tx_data=0, busy=0, done=0, counters 0.
REQ-032 rst SHALL dominate start in the same cycle.
REQ-033 After reset mid-transfer no further tx_start SHALL issue; UART finishes its current byte independently.

Structure
REQ-034 Shared package coproc_pkg SHALL hold the state enum typedef, ADDR_WIDTH/DATA_WIDTH default constants.
REQ-035 No sub-module required; single always_ff plus next-state always_comb.
REQ-036 Instantiated in top, driving BRAM port B and tx_uart, alongside write_controller on port A.

Verification
REQ-037 Bench: BRAM model (READ_LATENCY=1) filled addr i = i[7:0]; tx_uart model busy 10 cycles, 1 cycle after tx_start.
REQ-038 start, base=0x005, length=4 -> tx_data 0x05,0x06,0x07,0x08, four tx_start, one done, busy falls after done.
REQ-039 start, base=0x3FE, length=4 -> addrb 0x3FE,0x3FF,0x000,0x001; bytes 0xFE,0xFF,0x00,0x01.
REQ-040 start, length=0 -> done within 2 cycles, zero enb and tx_start pulses.
REQ-041 Second start during byte 2 of length=3 -> ignored, exactly 3 bytes, one done.
REQ-042 rst asserted in WAIT_TX of byte 2 -> all outputs 0 next cycle, no further tx_start, new start then works normally.
REQ-043 length=1024, base=0 -> 1024 bytes in order, single done, counter no overflow.
